// File: rtl/rx_decim_pkg.sv
// rtl/rx_decim_pkg.sv - shared widths, saturation limits and I/Q pair type for the rx packer
package rx_decim_pkg;

  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH = 16;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef struct packed {
    logic signed [DEF_OUT_WIDTH-1:0] i;
    logic signed [DEF_OUT_WIDTH-1:0] q;
  } iq_pair_t;

endpackage

// File: rtl/rx_decim_packer_if.sv
// rtl/rx_decim_packer_if.sv - interleaved I/Q word stream toward the USB-side packer
interface rx_decim_packer_if import rx_decim_pkg::*; #(
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
);

  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/rx_pair_fifo.sv
// rtl/rx_pair_fifo.sv - first-word-fall-through pair FIFO; a pop frees its slot for a same-cycle push
module rx_pair_fifo import rx_decim_pkg::*; #(
  parameter int WIDTH = 2*DEF_OUT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk_120mhz,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk_120mhz) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full, a push only arrives together with a pop, so it lands in the slot being vacated.
  always_ff @(posedge clk_120mhz) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rx_decim_packer.sv
// rtl/rx_decim_packer.sv - CIC decimation strobe, rounding/saturating capture and I,Q word interleaver
module rx_decim_packer import rx_decim_pkg::*; #(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int CIC_LATENCY = 1
) (
  input  logic                       clk_120mhz,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [7:0]                 decim_rate,
  input  logic [4:0]                 shift,
  output logic                       strobe_decim,
  input  logic signed [IN_WIDTH-1:0] i_in,
  input  logic signed [IN_WIDTH-1:0] q_in,
  rx_decim_packer_if.master          out_if,
  output logic                       overrun,
  output logic [15:0]                sample_count
);

  localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH+1)'(SAT_MAX);
  localparam logic signed [IN_WIDTH:0] SAT_LO = (IN_WIDTH+1)'(SAT_MIN);

  // Round-half-up arithmetic shift in one extra bit so the rounding add cannot wrap.
  function automatic logic [OUT_WIDTH-1:0] scale_sat(input logic signed [IN_WIDTH-1:0] x,
                                                     input logic [4:0] sh);
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] r;
    ext = {x[IN_WIDTH-1], x};
    rnd = '0;
    if (sh != 5'd0) rnd[{1'b0, sh} - 6'd1] = 1'b1;
    r = (ext + rnd) >>> sh;
    if (r > SAT_HI)      scale_sat = SAT_MAX;
    else if (r < SAT_LO) scale_sat = SAT_MIN;
    else                 scale_sat = r[OUT_WIDTH-1:0];
  endfunction

  logic                   active;
  logic [7:0]             cnt;
  logic [CIC_LATENCY-1:0] strobe_pipe;
  logic                   cap_en;
  logic                   pair_valid;
  iq_pair_t               pair_reg;
  iq_pair_t               head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   out_valid_int;
  logic                   pop;
  logic                   accept;
  logic                   phase;
  logic                   overrun_r;
  logic [15:0]            count_r;

  assign active = enable & ~reset;

  always_ff @(posedge clk_120mhz) begin
    if (!active)           cnt <= '0;
    else if (cnt == 8'd0)  cnt <= decim_rate - 8'd1;
    else                   cnt <= cnt - 8'd1;
  end

  assign strobe_decim = active && (cnt == 8'd0);

  always_ff @(posedge clk_120mhz) begin
    if (!active) begin
      strobe_pipe <= '0;
    end else begin
      strobe_pipe[0] <= strobe_decim;
      for (int k = 1; k < CIC_LATENCY; k++) strobe_pipe[k] <= strobe_pipe[k-1];
    end
  end

  assign cap_en = strobe_pipe[CIC_LATENCY-1];

  always_ff @(posedge clk_120mhz) begin
    if (!active) begin
      pair_valid <= 1'b0;
      pair_reg   <= '0;
    end else begin
      pair_valid <= cap_en;
      if (cap_en) pair_reg <= '{i: scale_sat(i_in, shift), q: scale_sat(q_in, shift)};
    end
  end

  assign out_valid_int = active & ~fifo_empty;
  assign pop           = out_valid_int & out_if.out_ready & phase;
  assign accept        = pair_valid & (~fifo_full | pop);

  rx_pair_fifo #(
    .WIDTH ($bits(iq_pair_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_120mhz (clk_120mhz),
    .reset      (reset),
    .clear      (~active),
    .push       (accept),
    .pop        (pop),
    .wr_data    (pair_reg),
    .rd_data    (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk_120mhz) begin
    if (!active) begin
      phase     <= 1'b0;
      overrun_r <= 1'b0;
      count_r   <= '0;
    end else begin
      if (out_valid_int && out_if.out_ready) phase <= ~phase;
      if (accept)          count_r   <= count_r + 16'd1;
      else if (pair_valid) overrun_r <= 1'b1;
    end
  end

  assign out_if.out_valid = out_valid_int;
  assign out_if.out_data  = !out_valid_int ? '0 : (phase ? head.q : head.i);
  assign overrun          = active & overrun_r;
  assign sample_count     = active ? count_r : 16'd0;

endmodule

// File: doc/rx_decim_packer.md
Name: rx_decim_packer

Overview:
Downstream companion to cic_decim in the receive chain. It generates the decimation strobe that drives the CIC. It captures the I and Q CIC outputs on each decimated sample, removes CIC bit growth with a programmable rounding shift, and saturates each value to 16-bit signed. It then buffers I/Q pairs in a small FIFO and emits them as an interleaved I,Q 16-bit word stream with a valid/ready handshake toward the USB-side packer.

Parameters:
IN_WIDTH, 32, width of CIC signal_out (signed).
OUT_WIDTH, 16, width of output words (signed).
FIFO_DEPTH, 4, number of {I,Q} pairs buffered; power of two.
CIC_LATENCY, 1, cycles from strobe_decim to valid CIC output.

Ports:
clk_120mhz  in  1  system clock.
reset  in  1  synchronous, active-high.
enable  in  1  receive path enable; low acts as soft clear.
decim_rate  in  8  decimation factor; 0 means 256.
shift  in  5  arithmetic right shift applied to CIC output (0..31).
strobe_decim  out  1  one-cycle pulse to CIC .strobe.
i_in  in  IN_WIDTH  CIC I output.
q_in  in  IN_WIDTH  CIC Q output.
out_data  out  OUT_WIDTH  interleaved sample word.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts word when high with out_valid.
overrun  out  1  sticky: a sample was dropped because the FIFO was full.
sample_count  out  16  pairs accepted into FIFO, wraps at 65535->0.

Behaviour:
- Reset, or enable low: all outputs are 0. This covers strobe_decim, out_data, out_valid, overrun and sample_count. Also cleared: down-counter, FIFO (flushed), I/Q phase (back to I), capture pipeline.
- Strobe counter: when reset|~enable, cnt<=0. Otherwise, if cnt==0 then cnt<=decim_rate-1 (8-bit wrap, so rate 0 loads 255). Otherwise cnt<=cnt-1.
- strobe_decim = enable & ~reset & (cnt==0). The first strobe occurs on the first cycle after enable rises. Period is decim_rate cycles; 256 when decim_rate=0; every cycle when decim_rate=1.
- decim_rate changes take effect at the next reload.
- Capture: strobe_decim is delayed by CIC_LATENCY cycles to give cap_en. On cap_en, i_in and q_in are sampled.
- Scale, per channel: if shift==0, r=x; else r=(x + (1<<(shift-1))) >>> shift, computed in IN_WIDTH+1 bits to avoid overflow.
- Saturation: clamp r to [-32768, 32767].
- The scaled pair is written to the FIFO one cycle after cap_en (pipeline register). Total latency from strobe_decim to the pair in the FIFO is CIC_LATENCY+2.
- FIFO full at write time: the pair is dropped, overrun<=1 (sticky until reset/~enable), and sample_count is unchanged. Otherwise, the pair is written and sample_count increments.
- Output: when the FIFO is non-empty, out_valid=1 and out_data = I of the head pair. On handshake (out_valid&out_ready), phase toggles to Q. On the Q handshake, the head pair pops and phase returns to I.
- While out_valid&~out_ready, out_data and out_valid hold stable.
- Output is registered (FIFO read-ahead). A pair written to an empty FIFO presents I on out_data the following cycle.
- Simultaneous write and pop on a full FIFO: the pop is processed first, so the write succeeds and no overrun occurs.
- Max sustainable rate: one pair per 2 cycles. decim_rate=1 with out_ready=1 therefore overruns after the FIFO fills.

Decomposition:
- Package rx_decim_pkg: IN_WIDTH/OUT_WIDTH defaults, SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000, and a typedef for the {I,Q} pair (2*OUT_WIDTH).
- Sub-module rx_pair_fifo: synchronous FIFO of FIFO_DEPTH x 2*OUT_WIDTH with full/empty, first-word-fall-through, and pop-before-push on full.
- Strobe counter and scale/saturate stay in the top module; the scale logic is a function reused for I and Q.

Test Plan:
1. decim_rate=4, enable rises at cycle 0 -> strobe_decim high on cycles 1,5,9,…; decim_rate=0 -> period 256 cycles.
2. i_in=32'h0010_0000, q_in=32'hFFF0_0000, shift=20, out_ready=1 -> out_data sequence 16'h0001, 16'hFFFF per strobe; sample_count increments each pair.
3. Rounding, shift=1: i_in=3 -> 2; i_in=-3 -> -1; i_in=1 -> 1; shift=0, i_in=5 -> 5.
4. Saturation, shift=8: i_in=32'h7FFF_FFFF -> 16'h7FFF; q_in=32'h8000_0000 -> 16'h8000.
5. decim_rate=2, out_ready=0 -> 4 pairs accepted, 5th dropped, overrun=1, sample_count=4. out_data holds I of the first pair. Raise out_ready -> 8 words drain in order, overrun stays 1.
6. Pulse enable low mid-stream with the FIFO half full -> next cycle out_valid=0, overrun=0, sample_count=0. After re-enable, the first word out is the I of a new sample.
